// File: rtl/risc_spm.sv
// 8-bit stored-program RISC: register file, ALU, control FSM and a 256x8
// unified instruction/data memory reachable as M2_MEM.memory.

module memory_unit #(
  parameter int word_size = 8,
  parameter int mem_depth = 256
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [word_size-1:0] addr,
  input  logic [word_size-1:0] data_in,
  output logic [word_size-1:0] data_out
);
  logic [word_size-1:0] memory [0:mem_depth-1];

  assign data_out = memory[addr];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= data_in;
  end
endmodule

module risc_spm #(
  parameter int word_size = 8,
  parameter int mem_depth = 256
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [2:0] {
    S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_x1, S_x2, S_halt
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_NOT = 4'h4, OP_RD  = 4'h5, OP_WR  = 4'h6, OP_BR  = 4'h7,
    OP_BRZ = 4'h8, OP_HALT = 4'hF
  } op_t;

  state_t state, next_state;

  logic [word_size-1:0] R0, R1, R2, R3;
  logic [word_size-1:0] PC, IR, Add_R, R_Y;
  logic                 Z;

  logic [word_size-1:0] mem_word, src_val, dest_val, alu_out, rf_wdata;
  logic [3:0]           opcode;
  logic                 ld_ir, inc_pc, addr_ld_pc, addr_ld_mem, ld_ry;
  logic                 wr_alu, wr_mem, pc_ld_mem, mem_we, rf_we;

  assign opcode = IR[7:4];

  memory_unit #(.word_size(word_size), .mem_depth(mem_depth)) M2_MEM (
    .clk     (clk),
    .we      (mem_we),
    .addr    (Add_R),
    .data_in (src_val),
    .data_out(mem_word)
  );

  always_comb begin
    src_val = R0;
    case (IR[3:2])
      2'd0: src_val = R0;
      2'd1: src_val = R1;
      2'd2: src_val = R2;
      2'd3: src_val = R3;
      default: src_val = R0;
    endcase
  end

  always_comb begin
    dest_val = R0;
    case (IR[1:0])
      2'd0: dest_val = R0;
      2'd1: dest_val = R1;
      2'd2: dest_val = R2;
      2'd3: dest_val = R3;
      default: dest_val = R0;
    endcase
  end

  // R_Y holds the source operand latched in decode; dest is read in execute
  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_ADD: alu_out = dest_val + R_Y;
      OP_SUB: alu_out = dest_val - R_Y;
      OP_AND: alu_out = dest_val & R_Y;
      OP_NOT: alu_out = ~R_Y;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_idle;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ld_ir       = 1'b0;
    inc_pc      = 1'b0;
    addr_ld_pc  = 1'b0;
    addr_ld_mem = 1'b0;
    ld_ry       = 1'b0;
    wr_alu      = 1'b0;
    wr_mem      = 1'b0;
    pc_ld_mem   = 1'b0;
    mem_we      = 1'b0;
    case (state)
      S_idle: next_state = S_fet1;
      S_fet1: begin
        addr_ld_pc = 1'b1;
        next_state = S_fet2;
      end
      S_fet2: begin
        ld_ir      = 1'b1;
        inc_pc     = 1'b1;
        next_state = S_dec;
      end
      S_dec: begin
        case (opcode)
          OP_NOP: next_state = S_fet1;
          OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
            ld_ry      = 1'b1;
            next_state = S_ex1;
          end
          OP_RD, OP_WR, OP_BR: begin
            addr_ld_pc = 1'b1;
            next_state = S_x1;
          end
          OP_BRZ: begin
            if (Z) begin
              addr_ld_pc = 1'b1;
              next_state = S_x1;
            end else begin
              inc_pc     = 1'b1;
              next_state = S_fet1;
            end
          end
          default: next_state = S_halt;
        endcase
      end
      S_ex1: begin
        wr_alu     = 1'b1;
        next_state = S_fet1;
      end
      S_x1: begin
        addr_ld_mem = 1'b1;
        inc_pc      = 1'b1;
        next_state  = S_x2;
      end
      S_x2: begin
        case (opcode)
          OP_RD:         wr_mem    = 1'b1;
          OP_WR:         mem_we    = ~rst;
          OP_BR, OP_BRZ: pc_ld_mem = 1'b1;
          default: ;
        endcase
        next_state = S_fet1;
      end
      S_halt: next_state = S_halt;
      default: next_state = S_idle;
    endcase
  end

  assign rf_we    = wr_alu | wr_mem;
  assign rf_wdata = wr_alu ? alu_out : mem_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      PC    <= '0;
      IR    <= '0;
      Add_R <= '0;
      R_Y   <= '0;
      Z     <= 1'b0;
      R0    <= '0;
      R1    <= '0;
      R2    <= '0;
      R3    <= '0;
    end else begin
      if (addr_ld_pc)       Add_R <= PC;
      else if (addr_ld_mem) Add_R <= mem_word;
      if (ld_ir) IR <= mem_word;
      if (pc_ld_mem)   PC <= mem_word;
      else if (inc_pc) PC <= PC + word_size'(1);
      if (ld_ry)  R_Y <= src_val;
      if (wr_alu) Z   <= (alu_out == '0);
      if (rf_we) begin
        case (IR[1:0])
          2'd0: R0 <= rf_wdata;
          2'd1: R1 <= rf_wdata;
          2'd2: R2 <= rf_wdata;
          2'd3: R3 <= rf_wdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_risc_spm.sv
// Bench for risc_spm: instruction-level reference model checked at every
// instruction boundary, plus directed programs with hand-computed results.

module tb_risc_spm;
  logic clk = 1'b0;
  logic rst = 1'b1;

  risc_spm #(.word_size(8), .mem_depth(256)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [256];
  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic       m_z;
  bit         m_halt = 0;
  int         last_wr = -1;
  bit         active = 0;
  bit         pending = 0;
  int         cyc = 0;
  int         next_bound = 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.M2_MEM.memory[i] !== m_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes differ, expected 0 at %0t", nm, bad, $time);
    end
  endtask

  function automatic int cycles_of(input logic [7:0] ins, input logic z);
    case (ins[7:4])
      4'h0:                   return 3;
      4'h1, 4'h2, 4'h3, 4'h4: return 4;
      4'h5, 4'h6, 4'h7:       return 5;
      4'h8:                   return z ? 5 : 3;
      default:                return 3;
    endcase
  endfunction

  // One whole instruction at architectural level
  task automatic step();
    logic [7:0] ins, a, res;
    logic [1:0] s, d;
    ins = m_mem[m_pc];
    m_pc = m_pc + 8'd1;
    s = ins[3:2];
    d = ins[1:0];
    last_wr = -1;
    case (ins[7:4])
      4'h0: ;
      4'h1, 4'h2, 4'h3, 4'h4: begin
        case (ins[7:4])
          4'h1:    res = m_r[d] + m_r[s];
          4'h2:    res = m_r[d] - m_r[s];
          4'h3:    res = m_r[d] & m_r[s];
          default: res = ~m_r[s];
        endcase
        m_r[d] = res;
        m_z = (res == 8'h00);
      end
      4'h5: begin a = m_mem[m_pc]; m_pc = m_pc + 8'd1; m_r[d] = m_mem[a]; end
      4'h6: begin a = m_mem[m_pc]; m_pc = m_pc + 8'd1; m_mem[a] = m_r[s]; last_wr = int'(a); end
      4'h7: begin a = m_mem[m_pc]; m_pc = m_mem[a]; end
      4'h8: begin
        if (m_z) begin a = m_mem[m_pc]; m_pc = m_mem[a]; end
        else m_pc = m_pc + 8'd1;
      end
      default: m_halt = 1;
    endcase
  endtask

  always begin : compare_proc
    logic r;
    @(posedge clk);
    r = rst;
    #1;
    if (r) begin
      active = 1;
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_pc = 8'h00;
      m_z = 1'b0;
      m_halt = 0;
      pending = 0;
      cyc = 0;
      next_bound = 1;
    end else if (active) begin
      cyc++;
      if (!m_halt && cyc == next_bound) begin
        if (pending) step();
        chk("PC_boundary", dut.PC, m_pc);
        if (last_wr >= 0) chk("mem_write", dut.M2_MEM.memory[last_wr], m_mem[last_wr]);
        if (m_halt) chk_mem("mem_at_halt");
        else begin
          next_bound = cyc + cycles_of(m_mem[m_pc], m_z);
          pending = 1;
        end
      end else if (m_halt) begin
        chk("PC_halted", dut.PC, m_pc);
      end
      chk("R0", dut.R0, m_r[0]);
      chk("R1", dut.R1, m_r[1]);
      chk("R2", dut.R2, m_r[2]);
      chk("R3", dut.R3, m_r[3]);
      chk("Z", {7'd0, dut.Z}, {7'd0, m_z});
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setmem(input int a, input logic [7:0] v);
    dut.M2_MEM.memory[a] <= v;
    m_mem[a] = v;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_PC"}, dut.PC, 8'h00);
    chk({tag, "_IR"}, dut.IR, 8'h00);
    chk({tag, "_AddR"}, dut.Add_R, 8'h00);
    chk({tag, "_R0"}, dut.R0, 8'h00);
    chk({tag, "_R1"}, dut.R1, 8'h00);
    chk({tag, "_R2"}, dut.R2, 8'h00);
    chk({tag, "_R3"}, dut.R3, 8'h00);
    chk({tag, "_Z"}, {7'd0, dut.Z}, 8'h00);
  endtask

  task automatic begin_load();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) setmem(i, 8'h00);
  endtask

  task automatic end_load();
    @(negedge clk);
    chk_cleared("reset");
    chk_mem("mem_after_reset");
    rst = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared(tag);
    rst = 1'b0;
  endtask

  task automatic load_loop();
    logic [7:0] p [15];
    p = '{8'h00, 8'h52, 8'h82, 8'h53, 8'h83, 8'h51, 8'h80, 8'h50,
          8'h81, 8'h21, 8'h80, 8'h86, 8'h1B, 8'h73, 8'h8C};
    for (int i = 0; i < 15; i++) setmem(i, p[i]);
    setmem(128, 8'd6);
    setmem(129, 8'd1);
    setmem(130, 8'd2);
    setmem(131, 8'd0);
    setmem(134, 8'd139);
    setmem(139, 8'hF0);
    setmem(140, 8'd9);
  endtask

  task automatic chk_loop_result(input string tag);
    chk({tag, "_PC"}, dut.PC, 8'd140);
    chk({tag, "_R0"}, dut.R0, 8'd1);
    chk({tag, "_R1"}, dut.R1, 8'd0);
    chk({tag, "_R2"}, dut.R2, 8'd2);
    chk({tag, "_R3"}, dut.R3, 8'd10);
    chk({tag, "_Z"}, {7'd0, dut.Z}, 8'd1);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [3:0] op, lo;
    if ($urandom_range(0, 99) < 3) return 8'($urandom_range(0, 255));
    op = 4'($urandom_range(0, 8));
    lo = 4'($urandom_range(0, 15));
    return {op, lo};
  endfunction

  initial begin
    // Reset with preloaded memory, then the counting loop
    begin_load();
    load_loop();
    end_load();
    run(1);
    chk("pc_before_nop", dut.PC, 8'd0);
    run(3);
    chk("pc_after_nop", dut.PC, 8'd1);
    run(126);
    chk_loop_result("loop");
    run(5);
    chk("loop_pc_frozen", dut.PC, 8'd140);

    // Reset in the middle of the loop restarts from address 0
    pulse_reset("restart");
    run(40);
    chk("mid_R2_loaded", dut.R2, 8'd2);
    pulse_reset("midreset");
    run(130);
    chk_loop_result("loop_after_reset");

    // ALU and flags
    begin_load();
    setmem(0, 8'h50); setmem(1, 8'd100);
    setmem(2, 8'h51); setmem(3, 8'd101);
    setmem(4, 8'h14); setmem(5, 8'h42);
    setmem(6, 8'h36); setmem(7, 8'hF0);
    setmem(100, 8'hFF); setmem(101, 8'h01);
    end_load();
    run(15);
    chk("add_R0", dut.R0, 8'h00);
    chk("add_Z", {7'd0, dut.Z}, 8'd1);
    run(4);
    chk("not_R2", dut.R2, 8'hFF);
    chk("not_Z", {7'd0, dut.Z}, 8'd0);
    run(4);
    chk("and_R2", dut.R2, 8'h01);
    run(10);
    chk("alu_halt_PC", dut.PC, 8'd8);

    // WR then RD through memory
    begin_load();
    setmem(0, 8'h53); setmem(1, 8'd150);
    setmem(2, 8'h6C); setmem(3, 8'd200);
    setmem(4, 8'h50); setmem(5, 8'd200);
    setmem(6, 8'hF0);
    setmem(150, 8'hA5);
    end_load();
    run(25);
    chk("wr_mem200", dut.M2_MEM.memory[200], 8'hA5);
    chk("rd_R0", dut.R0, 8'hA5);
    chk("wrrd_PC", dut.PC, 8'd7);

    // BRZ not taken skips its address byte
    begin_load();
    setmem(10, 8'h80); setmem(11, 8'd134);
    setmem(12, 8'hF0); setmem(134, 8'h20);
    end_load();
    run(34);
    chk("brz_nt_next_PC", dut.PC, 8'd12);
    run(10);
    chk("brz_nt_halt_PC", dut.PC, 8'd13);

    // Illegal opcode halts and freezes everything
    begin_load();
    setmem(0, 8'h52); setmem(1, 8'd130);
    setmem(2, 8'h90); setmem(3, 8'h14);
    setmem(130, 8'h3C);
    end_load();
    run(12);
    for (int i = 0; i < 20; i++) begin
      chk("illegal_PC", dut.PC, 8'd3);
      run(1);
    end
    chk("illegal_R2", dut.R2, 8'h3C);
    chk("illegal_R0", dut.R0, 8'h00);
    chk_mem("illegal_mem");

    // Random programs against the reference model
    for (int t = 0; t < 25; t++) begin
      begin_load();
      for (int i = 0; i < 256; i++) setmem(i, rand_byte());
      end_load();
      run(300);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
